fetch_stage: RTL and testbench

- Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage (control unit).
- Holds the program counter and drives the instruction ROM address.
- Captures the fetched word into the IF/ID boundary with stall (hold) and branch-flush support.
- Outputs ID_instruction / ID_PC / ID_valid to decode; takes branch redirect from downstream.

---
 rtl/fetch_stage.sv | 56 +++++
 tb/tb_fetch_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, ROM addressing and IF/ID boundary register
module fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int COUNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               IF_ID_enable,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic [31:0]        IF_instruction,
    output logic [31:0]        IF_PC,
    output logic [31:0]        ID_instruction,
    output logic [31:0]        ID_PC,
    output logic [31:0]        ID_PC_plus4,
    output logic               ID_valid,
    output logic [COUNT_W-1:0] fetch_count
);

    // PC state is kept at ROM width; the 32-bit views are zero-extended.
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;

    assign pc_plus4 = pc + ADDR_W'(4);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc             <= ADDR_W'(RESET_PC);
            ID_instruction <= '0;
            id_pc          <= '0;
            id_pc_plus4    <= '0;
            ID_valid       <= 1'b0;
            fetch_count    <= '0;
        end else if (branch_taken) begin
            // Redirect and flush; the bubble keeps the old ID_PC fields.
            pc             <= {branch_target[ADDR_W-1:2], 2'b00};
            ID_instruction <= '0;
            ID_valid       <= 1'b0;
        end else if (IF_ID_enable) begin
            pc             <= pc_plus4;
            ID_instruction <= IF_instruction;
            id_pc          <= pc;
            id_pc_plus4    <= pc_plus4;
            ID_valid       <= 1'b1;
            fetch_count    <= fetch_count + COUNT_W'(1);
        end
    end

    assign IF_PC       = 32'(pc);
    assign ID_PC       = 32'(id_pc);
    assign ID_PC_plus4 = 32'(id_pc_plus4);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table and scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        IF_ID_enable = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] IF_instruction;
    logic [31:0] IF_PC;
    logic [31:0] ID_instruction;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC_plus4;
    logic        ID_valid;
    logic [15:0] fetch_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] idpc;
        logic [31:0] p4;
        logic        v;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    fetch_stage #(.ADDR_W(8), .RESET_PC(0), .COUNT_W(16)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .IF_ID_enable(IF_ID_enable),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .IF_instruction(IF_instruction),
        .IF_PC(IF_PC),
        .ID_instruction(ID_instruction),
        .ID_PC(ID_PC),
        .ID_PC_plus4(ID_PC_plus4),
        .ID_valid(ID_valid),
        .fetch_count(fetch_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hE100_0000 ^ {a[15:0], a[15:0]};
    endfunction

    assign IF_instruction = rom_word(IF_PC);

    function automatic vec_t mk(input logic rst, input logic en, input logic br,
                                input logic [31:0] tgt, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] idpc,
                                input logic [31:0] p4, input logic v, input logic [15:0] cnt);
        vec_t r;
        r.rst = rst; r.en = en; r.br = br; r.tgt = tgt; r.pc = pc;
        r.ins = ins; r.idpc = idpc; r.p4 = p4; r.v = v; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t r);
        vec_t e;
        Reset = r.rst;
        IF_ID_enable = r.en;
        branch_taken = r.br;
        branch_target = r.tgt;
        sb.push_back(r);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = sb.pop_front();
            check("IF_PC", IF_PC, e.pc);
            check("ID_instruction", ID_instruction, e.ins);
            check("ID_PC", ID_PC, e.idpc);
            check("ID_PC_plus4", ID_PC_plus4, e.p4);
            check("ID_valid", {31'b0, ID_valid}, {31'b0, e.v});
            check("fetch_count", {16'b0, fetch_count}, {16'b0, e.cnt});
        end
    endtask

    initial begin
        // rst en br tgt | pc ins idpc p4 v cnt
        vecs.push_back(mk(1, 0, 0, 0,      0,     0,              0,     0,     0, 0));
        vecs.push_back(mk(1, 0, 0, 0,      0,     0,              0,     0,     0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      4,     rom_word(0),    0,     4,     1, 1));
        vecs.push_back(mk(0, 1, 0, 0,      8,     rom_word(4),    4,     8,     1, 2));
        vecs.push_back(mk(0, 0, 0, 0,      8,     rom_word(4),    4,     8,     1, 2));
        vecs.push_back(mk(0, 0, 0, 0,      8,     rom_word(4),    4,     8,     1, 2));
        vecs.push_back(mk(0, 0, 0, 0,      8,     rom_word(4),    4,     8,     1, 2));
        vecs.push_back(mk(0, 1, 0, 0,      12,    rom_word(8),    8,     12,    1, 3));
        vecs.push_back(mk(0, 1, 1, 32'h1E, 32'h1C, 0,             8,     12,    0, 3));
        vecs.push_back(mk(0, 1, 0, 0,      32'h20, rom_word(32'h1C), 32'h1C, 32'h20, 1, 4));
        vecs.push_back(mk(0, 0, 1, 32'h40, 32'h40, 0,             32'h1C, 32'h20, 0, 4));
        vecs.push_back(mk(0, 0, 1, 248,    248,   0,              32'h1C, 32'h20, 0, 4));
        vecs.push_back(mk(0, 1, 0, 0,      252,   rom_word(248),  248,   252,   1, 5));
        vecs.push_back(mk(0, 1, 0, 0,      0,     rom_word(252),  252,   0,     1, 6));
        vecs.push_back(mk(0, 1, 1, 32'h104, 4,    0,              252,   0,     0, 6));
        vecs.push_back(mk(0, 1, 0, 0,      8,     rom_word(4),    4,     8,     1, 7));
        vecs.push_back(mk(1, 0, 1, 32'h80, 0,     0,              0,     0,     0, 0));

        #2;
        foreach (vecs[i]) apply(vecs[i]);

        // Run to PC=20 with five fetches, then reset together with a branch.
        for (int k = 1; k <= 5; k++)
            apply(mk(0, 1, 0, 0, 32'(4 * k), rom_word(32'(4 * (k - 1))),
                     32'(4 * (k - 1)), 32'(4 * k), 1, 16'(k)));
        apply(mk(1, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0));
        // Released but stalled: still a bubble, nothing moves.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 4, rom_word(0), 0, 4, 1, 1));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
